// File: rtl/main_memory_server.sv
// main_memory_server: fixed-latency byte/half/word backing memory behind the arbitrated L1/L2 port.
// Define MEM_ACCESS_CHECK_EN to fault out-of-range, misaligned and size-3 accesses.
module main_memory_server #(
  parameter int XLEN = 32,
  parameter int MEM_WORDS = 4096,
  parameter int LATENCY = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_op,
  input  logic [1:0]      req_size,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_error
);
  localparam int AW = $clog2(MEM_WORDS);
  localparam int NB = XLEN / 8;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_nx;
  logic [7:0] cnt;
  logic lop;
  logic [1:0] lsz;
  logic [XLEN-1:0] laddr, lwd;
  logic [XLEN-1:0] mem [MEM_WORDS];
  logic [AW-1:0] idx;
  logic [1:0] off;
  logic [NB-1:0] be;
  logic [XLEN-1:0] mask, wsh, rd;
  logic fault, commit;
`ifdef MEM_ACCESS_CHECK_EN
  assign fault = |(laddr >> (AW + 2)) || lsz == 2'd3 || (lsz == 2'd1 && laddr[0]) || (lsz[1] && |laddr[1:0]);
`else
  logic unused_hi;
  assign unused_hi = ^laddr[XLEN-1:AW+2];
  assign fault = 1'b0;
`endif
  // Sub-word offsets align down; size 3 behaves as a word
  assign idx = laddr[AW+1:2];
  assign off = lsz == 2'd0 ? laddr[1:0] : lsz == 2'd1 ? {laddr[1], 1'b0} : 2'd0;
  assign be = (lsz == 2'd0 ? NB'(1) : lsz == 2'd1 ? NB'(3) : {NB{1'b1}}) << off;
  assign mask = lsz == 2'd0 ? XLEN'(8'hff) : lsz == 2'd1 ? XLEN'(16'hffff) : {XLEN{1'b1}};
  assign wsh = lwd << {off, 3'b000};
  assign rd = (mem[idx] >> {off, 3'b000}) & mask;
  assign commit = state == WAIT && cnt == 8'd0;
  always_ff @(posedge clk)
    state <= !reset_n ? IDLE : state_nx;
  always_comb
    state_nx = state == IDLE ? (req_valid ? WAIT : IDLE) :
               state == WAIT ? (cnt == 8'd0 ? RESP : WAIT) :
               (rsp_ready ? IDLE : RESP);
  always_comb begin
    req_ready = reset_n && state == IDLE;
    rsp_valid = state == RESP;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt <= 8'd0;
      rsp_rdata <= '0;
      rsp_error <= 1'b0;
    end else begin
      if (state == IDLE && req_valid) begin
        lop <= req_op;
        lsz <= req_size;
        laddr <= req_addr;
        lwd <= req_wdata;
        cnt <= 8'(LATENCY - 1);
      end else if (state == WAIT && cnt != 8'd0) begin
        cnt <= cnt - 8'd1;
      end
      if (commit) begin
        rsp_rdata <= (lop || fault) ? '0 : rd;
        rsp_error <= fault;
      end
    end
  end
  // Writes land on the WAIT->RESP edge, so an aborting reset drops them
  always_ff @(posedge clk)
    if (reset_n && commit && lop && !fault)
      for (int i = 0; i < NB; i++)
        if (be[i]) mem[idx][8*i +: 8] <= wsh[8*i +: 8];
endmodule

// File: tb/tb_main_memory_server.sv
// tb_main_memory_server: randomized checks of main_memory_server against a byte-array model.
module tb_main_memory_server;
  localparam int LATENCY = 4;
  localparam int MEM_WORDS = 4096;
  logic clk = 0;
  logic reset_n, req_valid, req_ready, req_op, rsp_valid, rsp_ready, rsp_error;
  logic [1:0] req_size;
  logic [31:0] req_addr, req_wdata, rsp_rdata;
  int vectors = 0;
  int miscompares = 0;
  logic [7:0] mb [MEM_WORDS*4];

  main_memory_server #(.XLEN(32), .MEM_WORDS(MEM_WORDS), .LATENCY(LATENCY)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error)
  );

  always #5 clk = ~clk;

  function automatic void model(input logic op, input logic [1:0] sz, input logic [31:0] a,
                                input logic [31:0] wd, output logic [31:0] rd, output logic err);
    int n;
    int base;
    n = sz == 0 ? 1 : sz == 1 ? 2 : 4;
    base = int'(a % (MEM_WORDS * 4)) / n * n;
    err = 1'b0;
`ifdef MEM_ACCESS_CHECK_EN
    err = a >= 32'(MEM_WORDS * 4) || a % n != 0 || sz == 2'd3;
`endif
    rd = '0;
    for (int k = 0; k < n; k++)
      if (!err) begin
        if (op) mb[base + k] = wd[8*k +: 8];
        else rd[8*k +: 8] = mb[base + k];
      end
  endfunction

  task automatic txn(input logic op, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd,
                     input int hold, output logic [31:0] rd, output logic er, output int lat);
    int t = 0;
    while (!req_ready && t < 20) begin @(negedge clk); t++; end
    req_valid = 1; req_op = op; req_size = sz; req_addr = a; req_wdata = wd;
    @(negedge clk);
    req_valid = 0; req_op = 1'($urandom); req_size = 2'($urandom); req_addr = $urandom; req_wdata = $urandom;
    lat = 0;
    while (!rsp_valid && lat < 300) begin @(negedge clk); lat++; end
    rd = rsp_rdata; er = rsp_error;
    repeat (hold) @(negedge clk);
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
  endtask

  task automatic test_reset();
    reset_n = 0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({req_ready, rsp_valid} !== 2'b00) begin
      miscompares++; $display("FAIL reset_hold: ready/valid=%b want 00", {req_ready, rsp_valid});
    end
    reset_n = 1;
    @(negedge clk);
    vectors++;
    if ({req_ready, rsp_valid, rsp_error, rsp_rdata} !== {3'b100, 32'h0}) begin
      miscompares++;
      $display("FAIL reset_idle: ready=%b valid=%b err=%b rdata=%h want 1 0 0 0", req_ready, rsp_valid, rsp_error, rsp_rdata);
    end
  endtask

  task automatic test_init();
    logic [31:0] rd, erd, d; logic er, eer; int lat;
    for (int i = 0; i < 64; i++) begin
      d = $urandom;
      model(1, 2, 32'(4 * i), d, erd, eer);
      txn(1, 2, 32'(4 * i), d, 0, rd, er, lat);
      vectors++;
      if ({rd, er} !== {erd, eer} || lat !== LATENCY) begin
        miscompares++; $display("FAIL init_write[%0d]: rdata=%h err=%b lat=%0d want %h %b %0d", i, rd, er, lat, erd, eer, LATENCY);
      end
    end
  endtask

  task automatic test_word_roundtrip();
    logic [31:0] rd, erd; logic er, eer; int lat;
    model(1, 2, 32'h100, 32'hDEADBEEF, erd, eer);
    txn(1, 2, 32'h100, 32'hDEADBEEF, 0, rd, er, lat);
    vectors++;
    if ({rd, er} !== 33'h0 || lat !== LATENCY) begin
      miscompares++; $display("FAIL word_write: rdata=%h err=%b lat=%0d want 0 0 %0d", rd, er, lat, LATENCY);
    end
    model(0, 2, 32'h100, 0, erd, eer);
    txn(0, 2, 32'h100, 0, 1, rd, er, lat);
    vectors++;
    if ({rd, er} !== {32'hDEADBEEF, 1'b0} || lat !== LATENCY) begin
      miscompares++; $display("FAIL word_read: rdata=%h err=%b lat=%0d want deadbeef 0 %0d", rd, er, lat, LATENCY);
    end
  endtask

  task automatic test_lanes();
    logic [31:0] rd, erd; logic er, eer; int lat;
    model(1, 2, 32'h20, 32'h11223344, erd, eer); txn(1, 2, 32'h20, 32'h11223344, 0, rd, er, lat);
    model(1, 0, 32'h21, 32'hFFFFFFAA, erd, eer); txn(1, 0, 32'h21, 32'hFFFFFFAA, 0, rd, er, lat);
    model(1, 1, 32'h22, 32'hFFFF5566, erd, eer); txn(1, 1, 32'h22, 32'hFFFF5566, 0, rd, er, lat);
    model(0, 2, 32'h20, 0, erd, eer); txn(0, 2, 32'h20, 0, 0, rd, er, lat);
    vectors++;
    if (rd !== 32'h5566AA44) begin
      miscompares++; $display("FAIL lanes_word: rdata=%h want 5566aa44", rd);
    end
    model(0, 0, 32'h23, 0, erd, eer); txn(0, 0, 32'h23, 0, 0, rd, er, lat);
    vectors++;
    if (rd !== 32'h00000055) begin
      miscompares++; $display("FAIL lanes_byte: rdata=%h want 00000055", rd);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd0, erd, erd2; logic eer, eer2; int lat;
    model(0, 2, 32'h8, 0, erd, eer);
    model(0, 0, 32'h5, 0, erd2, eer2);
    req_valid = 1; req_op = 0; req_size = 2; req_addr = 32'h8;
    @(negedge clk);
    req_valid = 0;
    lat = 0;
    while (!rsp_valid && lat < 300) begin @(negedge clk); lat++; end
    rd0 = rsp_rdata;
    vectors++;
    if (rd0 !== erd || lat !== LATENCY) begin
      miscompares++; $display("FAIL bp_first: rdata=%h lat=%0d want %h %0d", rd0, lat, erd, LATENCY);
    end
    req_valid = 1; req_op = 0; req_size = 0; req_addr = 32'h5;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++;
      if ({rsp_valid, req_ready, rsp_error, rsp_rdata} !== {3'b100, rd0}) begin
        miscompares++;
        $display("FAIL bp_hold[%0d]: valid=%b ready=%b err=%b rdata=%h want 1 0 0 %h", i, rsp_valid, req_ready, rsp_error, rsp_rdata, rd0);
      end
    end
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    vectors++;
    if ({rsp_valid, req_ready} !== 2'b01) begin
      miscompares++; $display("FAIL bp_after: valid/ready=%b want 01", {rsp_valid, req_ready});
    end
    @(negedge clk);
    req_valid = 0;
    lat = 0;
    while (!rsp_valid && lat < 300) begin @(negedge clk); lat++; end
    vectors++;
    if (rsp_rdata !== erd2 || lat !== LATENCY) begin
      miscompares++; $display("FAIL bp_second: rdata=%h lat=%0d want %h %0d", rsp_rdata, lat, erd2, LATENCY);
    end
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
  endtask

  task automatic test_reset_mid_wait();
    logic [31:0] rd, erd; logic er, eer; int lat; int seen = 0;
    req_valid = 1; req_op = 1; req_size = 2; req_addr = 32'h40; req_wdata = 32'hCAFEF00D;
    @(negedge clk);
    req_valid = 0; reset_n = 0;
    repeat (2) @(negedge clk);
    reset_n = 1;
    for (int i = 0; i < LATENCY + 3; i++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    vectors++;
    if (seen !== 0) begin
      miscompares++; $display("FAIL abort_no_rsp: valid cycles=%0d want 0", seen);
    end
    model(0, 2, 32'h40, 0, erd, eer);
    txn(0, 2, 32'h40, 0, 0, rd, er, lat);
    vectors++;
    if ({rd, er} !== {erd, eer} || rd === 32'hCAFEF00D) begin
      miscompares++; $display("FAIL abort_read: rdata=%h err=%b want %h %b", rd, er, erd, eer);
    end
  endtask

  task automatic test_boundary();
    logic [31:0] rd, erd; logic er, eer; int lat;
    model(0, 2, 32'h4000, 0, erd, eer);
    txn(0, 2, 32'h4000, 0, 0, rd, er, lat);
    vectors++;
`ifdef MEM_ACCESS_CHECK_EN
    if ({rd, er} !== {32'h0, 1'b1} || lat !== LATENCY) begin
`else
    if ({rd, er} !== {mb[3], mb[2], mb[1], mb[0], 1'b0} || lat !== LATENCY) begin
`endif
      miscompares++; $display("FAIL read_4000: rdata=%h err=%b lat=%0d want %h %b", rd, er, lat, erd, eer);
    end
    model(1, 2, 32'h2, 32'h0BADF00D, erd, eer);
    txn(1, 2, 32'h2, 32'h0BADF00D, 0, rd, er, lat);
    model(0, 2, 32'h0, 0, erd, eer);
    txn(0, 2, 32'h0, 0, 0, rd, er, lat);
    vectors++;
    if ({rd, er} !== {erd, eer}) begin
      miscompares++; $display("FAIL misaligned_word: rdata=%h err=%b want %h %b", rd, er, erd, eer);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, erd, a, d; logic er, eer, op; logic [1:0] sz; int lat;
    for (int i = 0; i < 200; i++) begin
      op = 1'($urandom); sz = 2'($urandom);
      a = 32'($urandom_range(0, 255)) + ($urandom_range(0, 3) == 0 ? 32'h4000 * $urandom_range(1, 3) : 32'h0);
      d = $urandom;
      model(op, sz, a, d, erd, eer);
      txn(op, sz, a, d, $urandom_range(0, 2), rd, er, lat);
      vectors++;
      if ({rd, er} !== {erd, eer} || lat !== LATENCY) begin
        miscompares++;
        $display("FAIL random[%0d] op=%b sz=%0d a=%h: rdata=%h err=%b lat=%0d want %h %b %0d", i, op, sz, a, rd, er, lat, erd, eer, LATENCY);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset_n = 0; req_valid = 0; req_op = 0; req_size = 0; req_addr = 0; req_wdata = 0; rsp_ready = 0;
    @(negedge clk);
    test_reset();
    test_init();
    test_word_roundtrip();
    test_lanes();
    test_backpressure();
    test_reset_mid_wait();
    test_boundary();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/main_memory_server.md
Name: main_memory_server

Overview:
- Backing-memory endpoint below the L1/L2 memory subsystem. It consumes the single arbitrated requester port that leaves the L1-to-L2 arbiter, the same traffic hmem_if carries.
- Services one word/half/byte read or write at a time from an internal word-addressed array, with a programmable fixed access latency.
- Used as the "main memory" in integration benches and FPGA builds.

Parameters:
- XLEN, 32, data and address width.
- MEM_WORDS, 4096, array depth in XLEN-bit words; power of two.
- LATENCY, 4, cycles from request accept to response valid; legal range 1..255.

Ports:
- clk  in  1  clock.
- reset_n  in  1  synchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  server can accept a request this cycle.
- req_op  in  1  0=read, 1=write.
- req_size  in  2  0=byte, 1=half, 2=word; 3 is reserved.
- req_addr  in  XLEN  byte address.
- req_wdata  in  XLEN  write data, right-aligned (byte in [7:0], half in [15:0]).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  requester accepts the response.
- rsp_rdata  out  XLEN  read data, right-aligned and zero-extended; 0 for writes.
- rsp_error  out  1  access fault (see Optional Feature); otherwise tied to 0.

Behaviour:
- Reset (reset_n low at a clk edge):
  - state=IDLE, req_ready=0 during reset, rsp_valid=0, rsp_rdata=0, rsp_error=0, latency counter=0.
  - Array contents are not cleared.
  - Reset asserted mid-transaction aborts it. A pending write that has not yet committed is dropped; a committed write stays. No response is produced.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid: latch op, size, addr, wdata; counter=LATENCY-1; go to WAIT.
- WAIT:
  - req_ready=0.
  - Counter decrements each cycle.
  - When counter==0: perform the access, register rsp_rdata and rsp_error, go to RESP.
- RESP:
  - rsp_valid=1, req_ready=0.
  - rsp_rdata and rsp_error hold stable until rsp_ready.
  - On rsp_valid & rsp_ready: clear rsp_valid, return to IDLE.
  - A new request is accepted no earlier than the cycle after the handshake, so there is no back-to-back overlap.
- Latency: accept at edge N gives rsp_valid high after edge N+LATENCY. LATENCY=1 therefore means response valid in the cycle after accept.
- Address decode:
  - word index = req_addr[log2(MEM_WORDS)+1:2].
  - Upper address bits are ignored (aliasing) unless MEM_ACCESS_CHECK_EN is defined.
- Byte lanes:
  - Byte uses addr[1:0] to select the lane.
  - Half uses addr[1] to select the lane.
  - Word uses all lanes.
  - Writes update only the enabled lanes; the other bytes of the word are preserved.
  - Reads shift the selected lane down to bit 0 and zero-extend.
- Misaligned half (addr[0]=1) or word (addr[1:0]!=0): the access is performed with the low address bits forced to zero (aligned down).
- Size 3 is treated as a word access.
- Write commit happens on the WAIT→RESP edge, so a read issued after the write's response observes the new data.
- req_* inputs are sampled only in IDLE; changes to them in other states are ignored.

Optional Feature:
- Macro: MEM_ACCESS_CHECK_EN.
- Defined:
  - Address bits above the array range nonzero, misalignment, or size 3 each set rsp_error=1.
  - Faulting writes do not modify the array.
  - Faulting reads return rsp_rdata=0.
  - Latency is unchanged.
- Undefined:
  - rsp_error is constant 0.
  - Address aliases modulo array size; misaligned accesses align down as above.

Test Plan:
- Reset then idle: hold reset_n=0 for 3 cycles, release -> req_ready=1 next cycle, rsp_valid=0, rsp_error=0.
- Word round trip, LATENCY=4: write 0xDEADBEEF to 0x100 accepted at cycle N -> rsp_valid at N+4 with rsp_rdata=0. Read 0x100 -> rsp_rdata=0xDEADBEEF.
- Byte/half lanes: word 0x11223344 at 0x20, then byte write 0xAA to 0x21 and half write 0x5566 to 0x22 -> word read 0x5566AA44; byte read at 0x23 returns 0x00000055.
- Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid -> rsp_valid and rsp_rdata stable and req_ready=0 throughout; a req_valid presented meanwhile is not accepted until the cycle after the handshake.
- Reset mid-WAIT: write 0xCAFEF00D to 0x40, assert reset_n=0 at accept+1 -> no response. After release, read 0x40 returns the prior contents.
- MEM_ACCESS_CHECK_EN with MEM_WORDS=4096:
  - Read 0x4000 -> rsp_error=1, rsp_rdata=0.
  - Word write 0x2 -> rsp_error=1, array unchanged.
  - Without the macro, read 0x4000 returns the contents of word 0.
